cu_cache_request_generator: RTL

- Descriptor-driven request stage directly upstream of the compute-unit cache wrapper's request port.
- Takes one descriptor (base address, element count, stride, read/write op) and emits a stream of CacheRequest beats.
- Throttles on the cache's registered request-FIFO state and on an outstanding-response budget.
- Counts returning responses and pulses done when every issued request has been answered.

---
 rtl/cu_cache_request_generator_pkg.sv | 54 +++++
 rtl/cu_cache_request_generator.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/cu_cache_request_generator_pkg.sv
// Shared cache front-end types plus the request generator's state and descriptor typedefs.
// Request, payload and FIFO-state layouts mirror the cache wrapper's request port.
package PKG_CACHE;

  localparam int CACHE_FRONTEND_ADDR_W = 32;
  localparam int CACHE_FRONTEND_DATA_W = 32;
  localparam int CACHE_META_W          = 16;
  localparam int CACHE_GEN_COUNT_W     = 32;

  typedef struct packed {
    logic                                 valid;
    logic [CACHE_FRONTEND_ADDR_W-1:0]     addr;
    logic [CACHE_FRONTEND_DATA_W-1:0]     wdata;
    logic [CACHE_FRONTEND_DATA_W/8-1:0]   wstrb;
  } CacheRequestIOB;

  typedef struct packed {
    CacheRequestIOB                       iob;
    logic [CACHE_META_W-1:0]              meta;
    logic [CACHE_FRONTEND_DATA_W-1:0]     data;
  } CacheRequestPayload;

  typedef struct packed {
    logic               valid;
    CacheRequestPayload payload;
  } CacheRequest;

  typedef struct packed {
    logic full;
    logic empty;
    logic prog_full;
    logic rd_rst_busy;
    logic wr_rst_busy;
  } FIFOStateSignalsOutput;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ISSUE,
    DRAIN,
    DONE
  } CacheGeneratorState;

  typedef struct packed {
    logic [CACHE_FRONTEND_ADDR_W-1:0]     base;
    logic [CACHE_GEN_COUNT_W-1:0]         count;
    logic [CACHE_FRONTEND_ADDR_W-1:0]     stride;
    logic                                 op;
    logic [CACHE_FRONTEND_DATA_W-1:0]     wdata;
    logic [CACHE_FRONTEND_DATA_W/8-1:0]   wstrb;
    logic [CACHE_META_W-1:0]              meta;
  } CacheGeneratorDescriptor;

endpackage

// File: rtl/cu_cache_request_generator.sv
// Descriptor-driven request generator feeding the compute-unit cache request port.
// Issues one strided request per cycle under FIFO and outstanding-budget throttling.
module cu_cache_request_generator
  import PKG_CACHE::*;
#(
  parameter int MAX_OUTSTANDING = 16,
  parameter int COUNT_W         = CACHE_GEN_COUNT_W,
  parameter int ADDR_W          = CACHE_FRONTEND_ADDR_W,
  parameter int DATA_W          = CACHE_FRONTEND_DATA_W
) (
  input  logic                  ap_clk,
  input  logic                  areset,
  input  logic                  start_in,
  input  logic [ADDR_W-1:0]     base_addr_in,
  input  logic [COUNT_W-1:0]    count_in,
  input  logic [ADDR_W-1:0]     stride_in,
  input  logic                  op_write_in,
  input  logic [DATA_W-1:0]     wdata_in,
  input  logic [DATA_W/8-1:0]   wstrb_in,
  input  logic [CACHE_META_W-1:0] meta_in,
  input  logic                  fifo_setup_signal_in,
  input  FIFOStateSignalsOutput fifo_request_signals_in,
  input  logic                  response_valid_in,
  output CacheRequest           request_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  error_out,
  output logic [COUNT_W-1:0]    issued_count_out,
  output logic [COUNT_W-1:0]    completed_count_out
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [OUT_W-1:0] MAX_OUT_Q = OUT_W'(MAX_OUTSTANDING);

  CacheGeneratorState      state_q, state_d;
  CacheGeneratorDescriptor desc_q, desc_d;
  CacheRequest             request_q, request_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [COUNT_W-1:0]      issued_q, issued_d;
  logic [COUNT_W-1:0]      completed_q, completed_d;
  logic [OUT_W-1:0]        outstanding_q, outstanding_d;
  logic                    error_q, error_d;

  logic                    issue;
  logic                    resp_ok;
  logic [COUNT_W-1:0]      remaining;
  logic                    fifo_unused;

  assign remaining   = desc_q.count - issued_q;
  assign resp_ok     = response_valid_in && (outstanding_q != '0);
  assign fifo_unused = ^{fifo_request_signals_in.full, fifo_request_signals_in.empty,
                         fifo_request_signals_in.rd_rst_busy, fifo_request_signals_in.wr_rst_busy};

  always_comb begin
    state_d       = state_q;
    desc_d        = desc_q;
    addr_d        = addr_q;
    issued_d      = issued_q;
    completed_d   = completed_q;
    outstanding_d = outstanding_q;
    error_d       = error_q;
    request_d     = '0;
    issue         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_in) begin
          desc_d.base   = base_addr_in;
          desc_d.count  = count_in;
          desc_d.stride = stride_in;
          desc_d.op     = op_write_in;
          desc_d.wdata  = wdata_in;
          desc_d.wstrb  = wstrb_in;
          desc_d.meta   = meta_in;
          issued_d      = '0;
          completed_d   = '0;
          outstanding_d = '0;
          error_d       = 1'b0;
          state_d       = SETUP;
        end
      end
      SETUP: begin
        addr_d = desc_q.base;
        if (desc_q.count == '0) begin
          state_d = DONE;
        end else if (!fifo_setup_signal_in) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        issue = (remaining != '0) && (outstanding_q < MAX_OUT_Q) &&
                !fifo_request_signals_in.prog_full && !fifo_setup_signal_in;
        if (issue && (remaining == COUNT_W'(1))) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((outstanding_q == '0) && (completed_q == desc_q.count)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (issue) begin
      request_d.valid               = 1'b1;
      request_d.payload.iob.valid   = 1'b1;
      request_d.payload.iob.addr    = addr_q;
      request_d.payload.iob.wdata   = desc_q.op ? desc_q.wdata : '0;
      request_d.payload.iob.wstrb   = desc_q.op ? desc_q.wstrb : '0;
      request_d.payload.meta        = desc_q.meta;
      addr_d                        = addr_q + desc_q.stride;
      issued_d                      = issued_q + COUNT_W'(1);
    end

    // Issue and response in the same cycle cancel out on the budget.
    case ({issue, resp_ok})
      2'b10:   outstanding_d = outstanding_q + OUT_W'(1);
      2'b01:   outstanding_d = outstanding_q - OUT_W'(1);
      default: outstanding_d = outstanding_d;
    endcase

    if (resp_ok) begin
      completed_d = completed_q + COUNT_W'(1);
    end
    if (response_valid_in && (outstanding_q == '0)) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q       <= IDLE;
      desc_q        <= '0;
      request_q     <= '0;
      addr_q        <= '0;
      issued_q      <= '0;
      completed_q   <= '0;
      outstanding_q <= '0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      desc_q        <= desc_d;
      request_q     <= request_d;
      addr_q        <= addr_d;
      issued_q      <= issued_d;
      completed_q   <= completed_d;
      outstanding_q <= outstanding_d;
      error_q       <= error_d;
    end
  end

  assign request_out         = request_q;
  assign busy_out            = (state_q == SETUP) || (state_q == ISSUE) || (state_q == DRAIN);
  assign done_out            = (state_q == DONE);
  assign error_out           = error_q;
  assign issued_count_out    = issued_q;
  assign completed_count_out = completed_q;

endmodule
